// File: rtl/bcd_updown_cntr.sv
// Multi-digit modulo up/down counter: parallel load, synchronous clear, optional
// saturation at the ends of the full range, and a registered wrap pulse.
module bcd_updown_cntr #(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned DIGIT_BITS = 4,
    parameter int unsigned DIGIT_MAX  = 9,
    parameter bit          SATURATE   = 1'b0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clear_i,
    input  logic                         load_i,
    input  logic [DIGITS*DIGIT_BITS-1:0] load_val_i,
    input  logic                         enable_i,
    input  logic                         up_i,
    output logic [DIGITS*DIGIT_BITS-1:0] count_o,
    output logic                         term_cnt_o,
    output logic                         wrap_o
);

    localparam int unsigned           CW   = DIGITS * DIGIT_BITS;
    localparam logic [DIGIT_BITS-1:0] DMAX = DIGIT_BITS'(DIGIT_MAX);

    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;
    logic                  wrap_q;
    logic                  wrap_d;
    logic                  all_max_c;
    logic                  all_zero_c;
    logic                  ripple_c;
    logic [DIGIT_BITS-1:0] digit_c;

    // Full-range end detection; term_cnt_o follows up_i with no register
    always_comb begin
        all_max_c  = 1'b1;
        all_zero_c = 1'b1;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (count_q[k*DIGIT_BITS +: DIGIT_BITS] != DMAX) all_max_c = 1'b0;
            if (count_q[k*DIGIT_BITS +: DIGIT_BITS] != '0)   all_zero_c = 1'b0;
        end
    end

    assign term_cnt_o = up_i ? all_max_c : all_zero_c;

    // Next count: clear > load > enabled count > hold
    always_comb begin
        count_d  = count_q;
        wrap_d   = 1'b0;
        ripple_c = 1'b1;
        digit_c  = '0;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            for (int k = 0; k < int'(DIGITS); k++) begin
                digit_c = load_val_i[k*DIGIT_BITS +: DIGIT_BITS];
                count_d[k*DIGIT_BITS +: DIGIT_BITS] = (digit_c > DMAX) ? DMAX : digit_c;
            end
        end else if (enable_i && !(term_cnt_o && SATURATE)) begin
            wrap_d = term_cnt_o;
            // Carry/borrow ripples upward while lower digits sit at their end value
            for (int k = 0; k < int'(DIGITS); k++) begin
                if (ripple_c) begin
                    digit_c = count_q[k*DIGIT_BITS +: DIGIT_BITS];
                    if (up_i) begin
                        count_d[k*DIGIT_BITS +: DIGIT_BITS] =
                            (digit_c == DMAX) ? '0 : digit_c + DIGIT_BITS'(1);
                        ripple_c = (digit_c == DMAX);
                    end else begin
                        count_d[k*DIGIT_BITS +: DIGIT_BITS] =
                            (digit_c == '0) ? DMAX : digit_c - DIGIT_BITS'(1);
                        ripple_c = (digit_c == '0);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count_o = count_q;
    assign wrap_o  = wrap_q;

endmodule

// File: doc/bcd_updown_cntr.md
Name: bcd_updown_cntr

Overview:
- Parametrised multi-digit modulo counter: DIGITS cascaded digit stages, each counting 0..DIGIT_MAX.
- Generalises the single cascadable stage with up/down counting, synchronous parallel load, synchronous clear, optional saturation, and a registered wrap pulse.
- Drives display/timer datapaths (e.g. seven-segment clock and stopwatch labs) directly; removes the need for external stage chaining.

Parameters:
- DIGITS, 4, number of cascaded digits (1..8).
- DIGIT_BITS, 4, width of each digit field.
- DIGIT_MAX, 9, terminal value of each digit (modulus-1); must satisfy DIGIT_MAX < 2**DIGIT_BITS.
- SATURATE, 0, 0 = wrap at the ends of the full range, 1 = hold at the ends of the full range.

Ports:
- clk_i, input, 1, positive-edge clock; sole clock.
- rst_i, input, 1, synchronous active-high reset.
- clear_i, input, 1, synchronous clear of all digits to 0.
- load_i, input, 1, synchronous parallel load from load_val_i.
- load_val_i, input, DIGITS*DIGIT_BITS, load value; digit k occupies bits [k*DIGIT_BITS +: DIGIT_BITS], digit 0 is least significant.
- enable_i, input, 1, count enable.
- up_i, input, 1, direction: 1 = increment, 0 = decrement; sampled only when enable_i=1.
- count_o, output, DIGITS*DIGIT_BITS, current count, same packing as load_val_i.
- term_cnt_o, output, 1, combinational: high when all digits are at DIGIT_MAX and up_i=1, or when all digits are 0 and up_i=0.
- wrap_o, output, 1, registered one-cycle pulse following a full-range wrap.

Behaviour:
- Priority at each rising edge: rst_i > clear_i > load_i > enable_i > hold.
- Reset: rst_i=1 → all digits 0 and wrap_o=0 at the next edge. term_cnt_o then reflects the all-zero count with the current up_i (1 when up_i=0).
- clear_i: all digits to 0; wrap_o=0.
- load_i: each digit takes its load_val_i field.
  - A field greater than DIGIT_MAX is clamped to DIGIT_MAX.
  - wrap_o=0.
  - enable_i is ignored in that cycle.
- Count up (enable_i=1, up_i=1):
  - Digit 0 increments every enabled cycle.
  - Digit k increments only when digits 0..k-1 are all at DIGIT_MAX.
  - A digit at DIGIT_MAX that increments goes to 0.
- Count down (enable_i=1, up_i=0):
  - Digit 0 decrements every enabled cycle.
  - Digit k decrements only when digits 0..k-1 are all 0.
  - A digit at 0 that decrements goes to DIGIT_MAX.
- Full-range boundary (enable_i=1 and term_cnt_o=1):
  - SATURATE=0: the count wraps (all-max → all-0 going up; all-0 → all-max going down), and wrap_o=1 in the next cycle.
  - SATURATE=1: the count holds and wrap_o stays 0.
- wrap_o is high for exactly one cycle per wrap. Consecutive wraps (DIGITS=1, DIGIT_MAX=0) give wrap_o high continuously.
- enable_i=0 holds the count; wrap_o=0.
- Direction change mid-count takes effect on the first enabled edge after the change, with no dead cycle.
- Latency: count_o updates one edge after the controlling input; term_cnt_o has zero latency (combinational from count and up_i).
- Digit values are never outside 0..DIGIT_MAX after reset.
- All registers are in the clk_i domain; no asynchronous paths.

Test Plan:
- Reset mid-count (DIGITS=2, DIGIT_MAX=9): count at 37, assert rst_i with enable_i=1 for 1 cycle → count_o=00 next edge, wrap_o=0, term_cnt_o=1 with up_i=0.
- Up cascade: from 00, enable_i=1, up_i=1 for 99 cycles → count_o=99 and term_cnt_o=1. One more cycle → count_o=00, wrap_o=1 for exactly one cycle. Check digit 1 steps on the 09→10 transition.
- Down borrow: load 10 then count down 1 → 09. Load 00 and count down 1 → 99 with wrap_o=1.
- Load clamp and priority: load_val_i=0xA5 → count_o=0x95. Assert clear_i, load_i and enable_i together → count_o=00. Assert load_i and enable_i together → load value with no increment.
- Saturation (SATURATE=1): at 99 with up 5 cycles → stays 99, wrap_o never high. At 00 with down 3 cycles → stays 00.
- Hold and direction flip: enable_i=0 for 10 cycles → count unchanged. Sequence 45 up,up,down,up → 46,47,46,47.
